// File: rtl/hier_stim_if.sv
// Valid/ready beat bus between hier_stim_gen and its mid-level consumers.
// Optional macro HIER_STIM_PARITY_EN adds an even-parity bit over {d,e,f}.
interface hier_stim_if #(
   parameter int D_WIDTH = 900,
   parameter int E_WIDTH = 10,
   parameter int F_WIDTH = 5
);
   logic               valid;
   logic               ready;
   logic [D_WIDTH-1:0] d;
   logic [E_WIDTH-1:0] e;
   logic [F_WIDTH-1:0] f;
   logic [7:0]         beat;
`ifdef HIER_STIM_PARITY_EN
   logic               parity;

   modport master (output valid, d, e, f, beat, parity, input ready);
   modport slave  (input valid, d, e, f, beat, parity, output ready);
`else
   modport master (output valid, d, e, f, beat, input ready);
   modport slave  (input valid, d, e, f, beat, output ready);
`endif
endinterface

// File: rtl/hier_stim_gen.sv
// Stimulus source: walking-one phase followed by an LFSR phase, emitted as
// BEATS beats each over a registered valid/ready bus.
// Optional macro HIER_STIM_PARITY_EN adds a registered parity output.
module hier_stim_gen #(
   parameter int          D_WIDTH = 900,
   parameter int          E_WIDTH = 10,
   parameter int          F_WIDTH = 5,
   parameter int          BEATS   = 16,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   hier_stim_if.master   bus,
   output logic          busy,
   output logic          done
);

   localparam int NREP = (D_WIDTH + 15) / 16;
   localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WALK, S_LFSR, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [7:0]         beat_q, beat_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [D_WIDTH-1:0] d_q, d_d;
   logic [E_WIDTH-1:0] e_q, e_d;
   logic [F_WIDTH-1:0] f_q, f_d;
   logic               xfer;
   logic               load;

   // Fibonacci LFSR step, taps 16/14/13/11
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Next-state, beat/LFSR advance and the next bus contents
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lfsr_d  = lfsr_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      d_d     = d_q;
      e_d     = e_q;
      f_d     = f_q;
      load    = 1'b0;
      xfer    = valid_q && bus.ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WALK;
               beat_d  = 8'd0;
               lfsr_d  = SEED;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               load    = 1'b1;
            end
         end
         S_WALK: begin
            if (xfer) begin
               load = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = S_LFSR;
                  beat_d  = 8'd0;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         S_LFSR: begin
            if (xfer) begin
               lfsr_d = lfsr_step(lfsr_q);
               if (beat_q == LAST_BEAT) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_q + 8'd1;
                  load   = 1'b1;
               end
            end
         end
         default: begin
            // DONE lasts one cycle; start is deliberately not looked at here
            state_d = S_IDLE;
         end
      endcase

      // Bus contents are built from the post-advance state so they are
      // ready in the output flops the cycle the beat becomes visible
      if (load) begin
         if (state_d == S_WALK) begin
            d_d = D_WIDTH'(1) << beat_d;
            e_d = E_WIDTH'(beat_d);
            f_d = ~F_WIDTH'(beat_d);
         end else begin
            d_d = D_WIDTH'({NREP{lfsr_d}});
            e_d = E_WIDTH'(lfsr_d);
            f_d = F_WIDTH'(lfsr_d >> (16 - F_WIDTH));
         end
      end
   end

   // State and output registers, all cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= 8'd0;
         lfsr_q  <= SEED;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         d_q     <= '0;
         e_q     <= '0;
         f_q     <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lfsr_q  <= lfsr_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         d_q     <= d_d;
         e_q     <= e_d;
         f_q     <= f_d;
      end
   end

`ifdef HIER_STIM_PARITY_EN
   logic parity_q, parity_d;

   // Parity follows the data registers, so it holds whenever they hold
   always_comb begin
      parity_d = ^{d_d, e_d, f_d};
   end

   // Parity register
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign bus.parity = parity_q;
`endif

   assign bus.valid = valid_q;
   assign bus.d     = d_q;
   assign bus.e     = e_q;
   assign bus.f     = f_q;
   assign bus.beat  = beat_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
